// File: rtl/door_pkg.sv
// Shared types and constants for the door access controller.
package door_pkg;

  localparam int unsigned KEY_W    = 12;
  localparam int unsigned KEY_STAR = 10;
  localparam int unsigned KEY_HASH = 11;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    LOCKOUT
  } door_state_t;

  // True when exactly one key line is active.
  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad front end: 2-flop synchroniser, one-hot filter and debounce counter.
module key_debounce
  import door_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [KEY_W-1:0] key_raw,
  output logic [KEY_W-1:0] key_stable
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC);

  logic [KEY_W-1:0] sync1_q, sync2_q;
  logic [KEY_W-1:0] filt;
  logic [KEY_W-1:0] cand_q;
  logic [KEY_W-1:0] stable_q;
  logic [CntW-1:0]  cnt_q;

  // Bring the asynchronous key lines into the clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Multi-key chords are meaningless to the core, so treat them as no key.
  always_comb begin
    filt = is_onehot(sync2_q) ? sync2_q : '0;
  end

  // Candidate tracking: the cycle a new candidate is captured counts as its first stable cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else if (filt != cand_q) begin
      cand_q <= filt;
      cnt_q  <= CntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_q <= cnt_q + CntW'(1);
    end else begin
      stable_q <= cand_q;
    end
  end

  assign key_stable = stable_q;

endmodule

// File: rtl/door_access_ctrl.sv
// Access controller: debounced key gating, failed-attempt lockout and door-unlock timing.
module door_access_ctrl
  import door_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000,
  parameter int unsigned MAX_FAIL     = 3,
  parameter int unsigned LOCKOUT_CYC  = 50_000_000,
  parameter int unsigned OPEN_CYC     = 100_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [KEY_W-1:0] key_raw,
  input  logic             core_open,
  input  logic             core_fail,
  output logic [KEY_W-1:0] key_out,
  output logic             door_unlock,
  output logic             locked_out,
  output logic [3:0]       fail_cnt,
  output logic             alarm
);

  localparam int unsigned TmrMax = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  // Timers load N-1 and leave on zero, giving exactly N cycles in the state.
  localparam logic [TmrW-1:0] OpenLoad = TmrW'(OPEN_CYC - 1);
  localparam logic [TmrW-1:0] LockLoad = TmrW'(LOCKOUT_CYC - 1);
  localparam logic [3:0]      MaxFail  = 4'(MAX_FAIL);

  logic [KEY_W-1:0] key_stable;
  door_state_t      state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [3:0]       fail_q, fail_d;
  logic             door_q, door_d;
  logic             lock_q, lock_d;
  logic             alarm_q, alarm_d;
  logic             open_q;
  logic             open_rise;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_raw   (key_raw),
    .key_stable(key_stable)
  );

  assign open_rise = core_open & ~open_q;

  // Next-state, timer and fail-counter logic; open beats a coincident fail.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    fail_d  = fail_q;
    alarm_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (open_rise) begin
          state_d = OPEN;
          tmr_d   = OpenLoad;
          fail_d  = '0;
        end else if (core_fail && (fail_q != MaxFail)) begin
          fail_d = fail_q + 4'd1;
          if (fail_d == MaxFail) begin
            state_d = LOCKOUT;
            tmr_d   = LockLoad;
            alarm_d = 1'b1;
          end
        end
      end
      OPEN: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    door_d = (state_d == OPEN);
    lock_d = (state_d == LOCKOUT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      fail_q  <= '0;
      door_q  <= 1'b0;
      lock_q  <= 1'b0;
      alarm_q <= 1'b0;
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      fail_q  <= fail_d;
      door_q  <= door_d;
      lock_q  <= lock_d;
      alarm_q <= alarm_d;
      open_q  <= core_open;
    end
  end

  // Keys never reach the core while locked out.
  always_comb begin
    key_out = lock_q ? '0 : key_stable;
  end

  assign door_unlock = door_q;
  assign locked_out  = lock_q;
  assign fail_cnt    = fail_q;
  assign alarm       = alarm_q;

endmodule

// File: tb/tb_door_access_ctrl.sv
// Directed bench for door_access_ctrl with short debounce/open/lockout timings.
module tb_door_access_ctrl;
  import door_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [KEY_W-1:0] key_raw;
  logic             core_open;
  logic             core_fail;
  logic [KEY_W-1:0] key_out;
  logic             door_unlock;
  logic             locked_out;
  logic [3:0]       fail_cnt;
  logic             alarm;

  int n_vec = 0;
  int n_err = 0;

  door_access_ctrl #(
    .DEBOUNCE_CYC(4),
    .MAX_FAIL    (3),
    .LOCKOUT_CYC (20),
    .OPEN_CYC    (10)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_raw    (key_raw),
    .core_open  (core_open),
    .core_fail  (core_fail),
    .key_out    (key_out),
    .door_unlock(door_unlock),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fail();
    core_fail = 1'b1;
    tick();
    core_fail = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KEY_W-1:0] hash_pat;
    int cnt, alarms, guard;
    logic key_seen;
    logic [3:0] fail_mid;

    reset_n   = 1'b0;
    key_raw   = '0;
    core_open = 1'b0;
    core_fail = 1'b0;
    #12;
    check_val("rst_key_out", 16'(key_out), 16'h0);
    check_val("rst_door", 16'(door_unlock), 16'h0);
    check_val("rst_locked", 16'(locked_out), 16'h0);
    check_val("rst_fail_cnt", 16'(fail_cnt), 16'h0);
    check_val("rst_alarm", 16'(alarm), 16'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) tick();

    // '#' key: latency 2+DEBOUNCE_CYC edges from the first sampling edge.
    hash_pat = '0;
    hash_pat[KEY_HASH] = 1'b1;
    key_raw = hash_pat;
    repeat (6) tick();
    check_val("hash_early", 16'(key_out), 16'h0);
    tick();
    check_val("hash_on", 16'(key_out), 16'h800);
    key_raw = '0;
    repeat (10) tick();
    check_val("hash_release", 16'(key_out), 16'h0);

    // Key 5 with a 2-cycle glitch at cycle 3: valid again at 5, seen after edge 11, gone after 16.
    for (int c = 0; c < 20; c++) begin
      key_raw = ((c < 3) || (c >= 5 && c < 10)) ? 12'h020 : 12'h000;
      tick();
      check_val($sformatf("glitch_c%0d", c), 16'(key_out),
                (c >= 11 && c < 16) ? 16'h020 : 16'h000);
    end

    // 3-cycle press never qualifies.
    for (int c = 0; c < 13; c++) begin
      key_raw = (c < 3) ? 12'h020 : 12'h000;
      tick();
      check_val($sformatf("short_c%0d", c), 16'(key_out), 16'h0);
    end

    // Two keys at once is filtered to no key.
    for (int c = 0; c < 18; c++) begin
      key_raw = (c < 10) ? 12'h022 : 12'h000;
      tick();
      check_val($sformatf("twokey_c%0d", c), 16'(key_out), 16'h0);
    end

    // Three fails 5 cycles apart -> lockout for 20 cycles.
    for (int i = 0; i < 3; i++) begin
      pulse_fail();
      check_val($sformatf("fail_step%0d", i), 16'(fail_cnt), 16'(i + 1));
      if (i < 2) begin
        check_val($sformatf("no_lock%0d", i), 16'(locked_out), 16'h0);
        repeat (4) tick();
      end
    end
    check_val("lock_entry", 16'(locked_out), 16'h1);
    key_raw  = 12'h020;
    cnt      = 0;
    alarms   = 0;
    key_seen = 1'b0;
    fail_mid = '0;
    while (locked_out && cnt < 100) begin
      cnt++;
      if (alarm) alarms++;
      if (key_out != '0) key_seen = 1'b1;
      core_fail = (cnt == 5);
      if (cnt == 8) fail_mid = fail_cnt;
      if (cnt == 10) key_raw = '0;
      tick();
    end
    core_fail = 1'b0;
    check_val("lock_len", 16'(cnt), 16'd20);
    check_val("alarm_pulses", 16'(alarms), 16'd1);
    check_val("lock_keys_gated", 16'(key_seen), 16'h0);
    check_val("lock_fail_sat", 16'(fail_mid), 16'd3);
    check_val("lock_exit_fail_cnt", 16'(fail_cnt), 16'h0);
    check_val("lock_exit_alarm", 16'(alarm), 16'h0);
    repeat (8) tick();

    // Two fails then open: counter cleared, door open 10 cycles, re-edge ignored.
    pulse_fail();
    repeat (4) tick();
    pulse_fail();
    check_val("pre_open_fail_cnt", 16'(fail_cnt), 16'd2);
    core_open = 1'b1;
    tick();
    check_val("open_rise_door", 16'(door_unlock), 16'h1);
    check_val("open_clr_fail", 16'(fail_cnt), 16'h0);
    cnt = 0;
    while (door_unlock && cnt < 100) begin
      cnt++;
      core_open = (cnt != 3);
      tick();
    end
    check_val("open_len", 16'(cnt), 16'd10);
    core_open = 1'b0;
    repeat (3) tick();

    // Open edge coincident with the third fail: open wins.
    pulse_fail();
    repeat (4) tick();
    pulse_fail();
    repeat (4) tick();
    core_open = 1'b1;
    core_fail = 1'b1;
    tick();
    core_fail = 1'b0;
    check_val("coinc_door", 16'(door_unlock), 16'h1);
    check_val("coinc_locked", 16'(locked_out), 16'h0);
    check_val("coinc_alarm", 16'(alarm), 16'h0);
    check_val("coinc_fail_cnt", 16'(fail_cnt), 16'h0);
    guard = 0;
    while (door_unlock && guard < 100) begin
      guard++;
      tick();
    end
    check_val("coinc_open_len", 16'(guard), 16'd10);
    core_open = 1'b0;
    repeat (3) tick();

    // Asynchronous reset while a key is shown in IDLE.
    key_raw = 12'h020;
    repeat (8) tick();
    check_val("idle_key_shown", 16'(key_out), 16'h020);
    #2 reset_n = 1'b0;
    #1;
    check_val("async_rst_key", 16'(key_out), 16'h0);
    tick();
    reset_n = 1'b1;

    // Asynchronous reset at cycle 7 of lockout.
    for (int i = 0; i < 3; i++) begin
      pulse_fail();
      if (i < 2) repeat (4) tick();
    end
    repeat (6) tick();
    check_val("lock_cyc7", 16'(locked_out), 16'h1);
    #2 reset_n = 1'b0;
    #1;
    check_val("async_rst_locked", 16'(locked_out), 16'h0);
    check_val("async_rst_fail", 16'(fail_cnt), 16'h0);
    check_val("async_rst_keyout", 16'(key_out), 16'h0);
    check_val("async_rst_door", 16'(door_unlock), 16'h0);
    tick();
    reset_n = 1'b1;
    tick();
    pulse_fail();
    check_val("post_rst_fail_cnt", 16'(fail_cnt), 16'd1);
    check_val("post_rst_locked", 16'(locked_out), 16'h0);
    repeat (8) tick();
    check_val("post_rst_key_ungated", 16'(key_out), 16'h020);
    key_raw = '0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
